progmem_loader: RTL and testbench

- Writer side of the 16-bit CPU's instruction memory. The CPU datapath only reads program memory at a 10-bit PC; this block fills that memory.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit words (high byte first), and writes them to consecutive addresses from 0.
- Holds the CPU in reset (cpu_hold) for the whole load.

---
 rtl/progmem_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_progmem_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/progmem_loader.sv
// ---------------------------------------------------------------------------
// progmem_loader
//
// Writer side of the 16-bit CPU's instruction memory. A byte stream arrives
// over a valid/ready handshake in the form
//     N[15:8], N[7:0], then N words each sent high byte first
// and the words are written to consecutive program-memory addresses from 0.
// The CPU is held in reset (cpu_hold) for the whole load.
//
// Parameters
//   ADDR_WIDTH  program memory address width (depth = 2^ADDR_WIDTH words)
//   TIMEOUT     max idle cycles between bytes while loading; 0 disables it
//
// Optional feature (compile-time macro PROGMEM_LOADER_CHECKSUM_EN)
//   When defined, a trailing checksum byte (XOR of every previous stream
//   byte, count bytes included) is expected in state CHK. Match -> DONE,
//   mismatch -> FAIL. Words are written as they arrive regardless.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      begin a load (only looked at in IDLE)
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle
//   mem_we     program memory write enable, one pulse per word
//   mem_addr   write address
//   mem_wd     write data
//   cpu_hold   CPU reset request while loading
//   busy       FSM not in IDLE (same as cpu_hold)
//   done       one-cycle pulse at successful end of load
//   err        sticky error flag, cleared by the next accepted start / reset
//   word_cnt   words written in the current / last load
// ---------------------------------------------------------------------------
module progmem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wd,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    // Largest legal word count; compared in 17 bits so N=2^16-1 never wraps.
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    // Idle counter sizing. With TIMEOUT=0 the counter is a harmless 1-bit
    // toggle that never reaches the compare below.
    localparam int          TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [TW-1:0]         IDLE_ONE = TW'(1);

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        DONE,
        FAIL
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    // State entered once the last word (or a zero count) has been handled.
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     n_cnt;      // word count N from the stream header
    logic [TW-1:0]   idle_cnt;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    logic [7:0]      chk;        // running XOR of accepted bytes
`endif

    logic            xfer;
    logic            start_acc;
    logic            last_word;
    logic            timeout_hit;
    logic [15:0]     n_full;

    // States in which a stream byte may be consumed.
    function automatic logic stream_state(input state_t s);
        logic r;
        r = (s == CNT_HI) || (s == CNT_LO) || (s == DAT_HI) || (s == DAT_LO);
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        r = r || (s == CHK);
`endif
        return r;
    endfunction

    // in_ready is a registered decode of the state, so it is high exactly
    // in the stream states.
    assign xfer      = in_valid & in_ready;
    assign start_acc = (state == IDLE) && start;

    // Full count as seen while its low byte is on the bus.
    assign n_full    = {n_cnt[15:8], in_data};

    // word_cnt equals the write index during WRITE, so this flags index N-1.
    assign last_word = ((17'(word_cnt) + 17'd1) == {1'b0, n_cnt});

    assign timeout_hit = (TIMEOUT > 0) && in_ready && !in_valid &&
                         (idle_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CNT_HI;
            CNT_HI: if (xfer)  state_nxt = CNT_LO;
            CNT_LO: if (xfer) begin
                        if (n_full == 16'd0)
                            state_nxt = END_ST;
                        else if ({1'b0, n_full} > DEPTH)
                            state_nxt = FAIL;
                        else
                            state_nxt = DAT_HI;
                    end
            DAT_HI: if (xfer)  state_nxt = DAT_LO;
            DAT_LO: if (xfer)  state_nxt = WRITE;
            WRITE:  state_nxt = last_word ? END_ST : DAT_HI;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            CHK:    if (xfer)  state_nxt = (in_data == chk) ? DONE : FAIL;
`endif
            DONE:   state_nxt = IDLE;
            FAIL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A stall that runs out the idle budget overrides everything else;
        // it can only fire in a stream state with no byte offered.
        if (timeout_hit) state_nxt = FAIL;
    end

    // State and all outputs update together; outputs are decoded from the
    // next state so they are flops, not combinational decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            n_cnt    <= '0;
            idle_cnt <= '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            chk      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            in_ready <= stream_state(state_nxt);
            cpu_hold <= (state_nxt != IDLE);
            busy     <= (state_nxt != IDLE);
            mem_we   <= (state_nxt == WRITE);
            done     <= (state_nxt == DONE);

            if (state_nxt == FAIL)
                err <= 1'b1;
            else if (start_acc)
                err <= 1'b0;

            if (start_acc) begin
                word_cnt <= '0;
                mem_addr <= '0;
                n_cnt    <= '0;
            end

            if (xfer) begin
                case (state)
                    CNT_HI:  n_cnt[15:8]  <= in_data;
                    CNT_LO:  n_cnt[7:0]   <= in_data;
                    DAT_HI:  mem_wd[15:8] <= in_data;
                    DAT_LO:  mem_wd[7:0]  <= in_data;
                    default: ;
                endcase
            end

            // The address stops at the last written word so it never wraps
            // past 2^ADDR_WIDTH-1 on a full-depth load.
            if (state == WRITE) begin
                word_cnt <= word_cnt + CNT_ONE;
                if (!last_word) mem_addr <= mem_addr + ADDR_ONE;
            end

            // Cleared on any transfer and outside the stream states (which
            // covers leaving IDLE); counts stalled stream cycles otherwise.
            if (xfer || !in_ready)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_ONE;

`ifdef PROGMEM_LOADER_CHECKSUM_EN
            if (start_acc)
                chk <= '0;
            else if (xfer)
                chk <= chk ^ in_data;
`endif
        end
    end

endmodule

// File: tb/tb_progmem_loader.sv
// ---------------------------------------------------------------------------
// tb_progmem_loader
//
// Table of whole-load vectors (count, gap pattern, expected error / write
// count / word_cnt) driven through the loader and checked against a write
// log, plus hand-written sequences for reset mid-stream, the idle timeout
// (second instance with TIMEOUT=8) and, when built with
// PROGMEM_LOADER_CHECKSUM_EN, a bad checksum.
// ---------------------------------------------------------------------------
module tb_progmem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_hold, busy, done, err;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wd;
    logic [10:0] word_cnt;

    logic        start_t = 1'b0;
    logic [7:0]  in_data_t = 8'h00;
    logic        in_valid_t = 1'b0;
    logic        in_ready_t, mem_we_t, cpu_hold_t, busy_t, done_t, err_t;
    logic [9:0]  mem_addr_t;
    logic [15:0] mem_wd_t;
    logic [10:0] word_cnt_t;

    progmem_loader #(.ADDR_WIDTH(10), .TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    progmem_loader #(.ADDR_WIDTH(10), .TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .in_data(in_data_t),
        .in_valid(in_valid_t), .in_ready(in_ready_t), .mem_we(mem_we_t),
        .mem_addr(mem_addr_t), .mem_wd(mem_wd_t), .cpu_hold(cpu_hold_t),
        .busy(busy_t), .done(done_t), .err(err_t), .word_cnt(word_cnt_t)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Write / done log, sampled on the falling edge.
    int          wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    int          done_tot;
    int          done_cyc;
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(mem_wd);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_tot <= done_tot + 1;
            done_cyc <= cyc;
        end
    end

    int    total = 0;
    int    bad   = 0;
    string tag   = "init";
    int    lo_q[$];
    int    hold_gap;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    bit    bad_chk_sel = 1'b0;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    function automatic logic [15:0] wgen(input int i, input logic [15:0] w0);
        if (i == 0) return w0;
        if (i == 1) return 16'h5678;
        return 16'(i) ^ 16'hC3A5;
    endfunction

    // Run one whole load: start pulse, header, words (and checksum when
    // built in), optional random gaps on in_valid, then wait for IDLE.
    task automatic do_load(input int n, input bit gaps, input logic [15:0] w0);
        logic [7:0]  bq[$];
        logic [15:0] nn, w;
        int idx, guard, nw, g;
        nn = 16'(n);
        bq.push_back(nn[15:8]);
        bq.push_back(nn[7:0]);
        nw = (n > 1024) ? 0 : n;
        for (int i = 0; i < nw; i++) begin
            w = wgen(i, w0);
            bq.push_back(w[15:8]);
            bq.push_back(w[7:0]);
        end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (bq[i]) x ^= bq[i];
            if (n <= 1024) bq.push_back(bad_chk_sel ? (x ^ 8'h01) : x);
        end
`endif
        lo_q.delete();
        hold_gap = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("hold_on", {cpu_hold, busy}, 2'b11);
        idx = 0; guard = 0;
        while (idx < bq.size() && guard < 10000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = bq[idx];
            end
            if (!cpu_hold) hold_gap++;
            if (in_valid && in_ready) begin
                if (idx >= 3 && idx[0] && idx < 2 + 2 * nw) lo_q.push_back(cyc);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("stream_sent", idx, bq.size());
        g = 0;
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("end_idle", {cpu_hold, busy}, 2'b00);
    endtask

    task automatic check_load(input logic [15:0] w0, input bit exp_err,
                              input int exp_we, input int exp_wc,
                              input int we_base, input int done_base);
        int bad_data, bad_lat, nwr;
        nwr = wa_q.size() - we_base;
        chk("err", err, exp_err);
        chk("we_count", nwr, exp_we);
        chk("word_cnt", word_cnt, exp_wc);
        bad_data = 0; bad_lat = 0;
        for (int j = 0; j < nwr; j++) begin
            if (wa_q[we_base + j] != j || wd_q[we_base + j] != wgen(j, w0)) bad_data++;
            if (j < lo_q.size()) begin
                if (wc_q[we_base + j] != lo_q[j] + 1) bad_lat++;
            end else begin
                bad_lat++;
            end
        end
        chk("data", bad_data, 0);
        chk("we_latency", bad_lat, 0);
        chk("done_pulses", done_tot - done_base, exp_err ? 0 : 1);
        chk("hold_gap", hold_gap, 0);
`ifndef PROGMEM_LOADER_CHECKSUM_EN
        if (!exp_err && nwr > 0) chk("done_latency", done_cyc, wc_q[wa_q.size() - 1] + 1);
`endif
    endtask

    typedef struct {
        int          n;
        bit          gaps;
        logic [15:0] w0;
        bit          exp_err;
        int          exp_we;
        int          exp_wc;
    } vec_t;

    vec_t vt[8];

    initial begin
        int wb, db;
        vt[0] = '{n: 2,    gaps: 0, w0: 16'h1234, exp_err: 0, exp_we: 2,    exp_wc: 2};
        vt[1] = '{n: 2,    gaps: 1, w0: 16'h1234, exp_err: 0, exp_we: 2,    exp_wc: 2};
        vt[2] = '{n: 0,    gaps: 0, w0: 16'h1234, exp_err: 0, exp_we: 0,    exp_wc: 0};
        vt[3] = '{n: 1,    gaps: 1, w0: 16'h1234, exp_err: 0, exp_we: 1,    exp_wc: 1};
        vt[4] = '{n: 5,    gaps: 1, w0: 16'h1234, exp_err: 0, exp_we: 5,    exp_wc: 5};
        vt[5] = '{n: 1024, gaps: 0, w0: 16'h1234, exp_err: 0, exp_we: 1024, exp_wc: 1024};
        vt[6] = '{n: 1025, gaps: 0, w0: 16'h1234, exp_err: 1, exp_we: 0,    exp_wc: 0};
        vt[7] = '{n: 3,    gaps: 0, w0: 16'h1234, exp_err: 0, exp_we: 3,    exp_wc: 3};

        // Reset state
        repeat (3) @(negedge clk);
        tag = "reset";
        chk("outs", {in_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done, err, word_cnt}, 0);
        chk("outs_t", {in_ready_t, cpu_hold_t, busy_t, err_t, word_cnt_t}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Table of whole loads
        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("v%0d_n%0d", i, vt[i].n);
            wb = wa_q.size();
            db = done_tot;
            do_load(vt[i].n, vt[i].gaps, vt[i].w0);
            check_load(vt[i].w0, vt[i].exp_err, vt[i].exp_we, vt[i].exp_wc, wb, db);
        end

        // Reset in the middle of a load, then a clean N=1 load
        tag = "midreset";
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_data = 8'h00; @(negedge clk);
        in_data = 8'h04; @(negedge clk);
        in_data = 8'h11; @(negedge clk);
        in_valid = 1'b0;
        chk("busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("outs", {in_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done, err, word_cnt}, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        tag = "after_reset";
        wb = wa_q.size();
        db = done_tot;
        do_load(1, 0, 16'hABCD);
        check_load(16'hABCD, 0, 1, 1, wb, db);

        // Idle timeout on the TIMEOUT=8 instance
        tag = "timeout";
        @(negedge clk); start_t = 1'b1;
        @(negedge clk); start_t = 1'b0;
        in_valid_t = 1'b1; in_data_t = 8'h00; @(negedge clk);
        in_data_t = 8'h01; @(negedge clk);
        in_data_t = 8'hAB; @(negedge clk);
        in_valid_t = 1'b0;
        repeat (7) @(negedge clk);
        chk("err_at7", {err_t, cpu_hold_t}, 2'b01);
        @(negedge clk);
        chk("err_at8", {err_t, cpu_hold_t}, 2'b11);
        @(negedge clk);
        chk("hold_drop", {err_t, cpu_hold_t, busy_t}, 3'b100);
        @(negedge clk); start_t = 1'b1;
        @(negedge clk); start_t = 1'b0;
        chk("err_cleared", {err_t, cpu_hold_t}, 2'b01);

`ifdef PROGMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: error, but the word is still written
        tag = "bad_chk";
        bad_chk_sel = 1'b1;
        wb = wa_q.size();
        db = done_tot;
        do_load(1, 0, 16'hABCD);
        check_load(16'hABCD, 1, 1, 1, wb, db);
        bad_chk_sel = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
